// File: rtl/dll_auto_truncate_pkg.sv
// rtl/dll_auto_truncate_pkg.sv - shared helpers for the auto-ranging DLL truncator
package dll_auto_truncate_pkg;

  typedef enum logic {
    ACQUIRE = 1'b0,
    TRACK   = 1'b1
  } dll_state_e;

  // Position of the highest set bit, or -1 when the vector is zero.
  function automatic int msb_pos(input logic [63:0] v);
    msb_pos = -1;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) msb_pos = i;
    end
  endfunction

  function automatic int clamp_index(input int v, input int lo, input int hi);
    if (v < lo)      clamp_index = lo;
    else if (v > hi) clamp_index = hi;
    else             clamp_index = v;
  endfunction

endpackage

// File: rtl/dll_window_round.sv
// rtl/dll_window_round.sv - combinational window select, round-half-up and saturate
module dll_window_round #(
  parameter int IN_WIDTH    = 36,
  parameter int OUT_WIDTH   = 11,
  parameter int INDEX_WIDTH = 6
) (
  input  logic [IN_WIDTH-1:0]    in,
  input  logic [INDEX_WIDTH-1:0] index,
  output logic [OUT_WIDTH-1:0]   out,
  output logic                   sat
);

  localparam int MIN_INDEX = OUT_WIDTH - 1;
  localparam logic [OUT_WIDTH-1:0] MAX_POS = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] MIN_NEG = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic signed [IN_WIDTH-1:0] hi;
  logic signed [IN_WIDTH-1:0] win;
  logic [OUT_WIDTH-1:0]       trunc;
  logic                       rbit;
  logic                       sign;
  logic                       range_err;
  logic                       round_ovf;

  always_comb begin
    sign  = in[IN_WIDTH-1];
    // Everything at and above the window MSB must be pure sign extension.
    hi    = $signed(in) >>> index;
    win   = $signed(in) >>> (index - INDEX_WIDTH'(MIN_INDEX));
    trunc = win[OUT_WIDTH-1:0];
    rbit  = 1'b0;
    if (index > INDEX_WIDTH'(MIN_INDEX)) rbit = in[index - INDEX_WIDTH'(OUT_WIDTH)];
    range_err = (hi != '0) && (hi != '1);
    round_ovf = (trunc == MAX_POS) && rbit;
    sat = range_err || round_ovf;
    if (range_err)      out = sign ? MIN_NEG : MAX_POS;
    else if (round_ovf) out = MAX_POS;
    else                out = trunc + OUT_WIDTH'(rbit);
  end

endmodule

// File: rtl/dll_auto_truncate.sv
// rtl/dll_auto_truncate.sv - auto-ranging truncator between correlator accumulators and DLL discriminator
module dll_auto_truncate
  import dll_auto_truncate_pkg::*;
#(
  parameter int IN_WIDTH    = 36,
  parameter int OUT_WIDTH   = 11,
  parameter int INDEX_WIDTH = 6,
  parameter int MIN_INDEX   = OUT_WIDTH - 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [IN_WIDTH-1:0]    in,
  input  logic                   epoch_end,
  input  logic                   manual,
  input  logic [INDEX_WIDTH-1:0] manual_index,
  output logic                   out_valid,
  output logic [OUT_WIDTH-1:0]   out,
  output logic                   sat,
  output logic [INDEX_WIDTH-1:0] index
);

  dll_state_e             state;
  logic [IN_WIDTH-1:0]    peak;
  logic [IN_WIDTH-1:0]    mag;
  logic [IN_WIDTH-1:0]    peak_next;
  logic [INDEX_WIDTH-1:0] req;
  logic [INDEX_WIDTH-1:0] manual_clamped;
  logic [OUT_WIDTH-1:0]   w_out;
  logic                   w_sat;

  dll_window_round #(
    .IN_WIDTH    (IN_WIDTH),
    .OUT_WIDTH   (OUT_WIDTH),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_window (
    .in    (in),
    .index (index),
    .out   (w_out),
    .sat   (w_sat)
  );

  // One's-complement magnitude avoids overflow on the most negative sample.
  always_comb begin
    mag       = in[IN_WIDTH-1] ? ~in : in;
    peak_next = (in_valid && (mag > peak)) ? mag : peak;
    if (peak_next == '0)
      req = INDEX_WIDTH'(MIN_INDEX);
    else
      req = INDEX_WIDTH'(clamp_index(msb_pos(64'(peak_next)) + 1, MIN_INDEX, IN_WIDTH - 1));
    manual_clamped = INDEX_WIDTH'(clamp_index(int'(manual_index), MIN_INDEX, IN_WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out       <= '0;
      sat       <= 1'b0;
      index     <= INDEX_WIDTH'(IN_WIDTH - 1);
      peak      <= '0;
      state     <= ACQUIRE;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out <= w_out;
        sat <= w_sat;
      end
      peak <= epoch_end ? '0 : peak_next;
      if (manual) begin
        index <= manual_clamped;
        state <= ACQUIRE;
      end else if (epoch_end) begin
        case (state)
          ACQUIRE: begin
            index <= req;
            state <= TRACK;
          end
          TRACK: begin
            // Grow immediately to avoid clipping, shrink one bit per epoch.
            if (req > index)      index <= req;
            else if (req < index) index <= index - 1'b1;
          end
          default: state <= ACQUIRE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dll_auto_truncate.sv
// tb/tb_dll_auto_truncate.sv - directed self-checking bench for dll_auto_truncate
module tb_dll_auto_truncate;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [35:0] in;
  logic        epoch_end;
  logic        manual;
  logic [5:0]  manual_index;
  logic        out_valid;
  logic [10:0] out;
  logic        sat;
  logic [5:0]  index;

  int total_checks = 0;
  int passed_checks = 0;

  dll_auto_truncate dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in           (in),
    .epoch_end    (epoch_end),
    .manual       (manual),
    .manual_index (manual_index),
    .out_valid    (out_valid),
    .out          (out),
    .sat          (sat),
    .index        (index)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total_checks++;
    assert (obs === exp) passed_checks++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic sample(input longint v);
    in = 36'(v);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic epoch();
    epoch_end = 1'b1;
    tick();
    epoch_end = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in = '0; epoch_end = 1'b0;
    manual = 1'b0; manual_index = '0;
    tick(); tick();
    reset = 1'b0;
    chk("reset_out", $signed(out), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_sat", int'(sat), 0);
    chk("reset_index", int'(index), 35);

    sample(1000 * (64'd1 << 25));
    chk("full_scale_out", $signed(out), 1000);
    chk("full_scale_sat", int'(sat), 0);
    chk("full_scale_valid", int'(out_valid), 1);
    chk("full_scale_index", int'(index), 35);

    // Reset discards the large peak accumulated above.
    reset = 1'b1; tick(); reset = 1'b0;
    sample(300); sample(1500); sample(-800);
    epoch();
    chk("acquire_index", int'(index), 11);
    sample(1500);
    chk("acquire_out", $signed(out), 750);
    chk("acquire_sat", int'(sat), 0);

    sample(5000);
    chk("ovr_pos_out", $signed(out), 1023);
    chk("ovr_pos_sat", int'(sat), 1);
    sample(-5000);
    chk("ovr_neg_out", $signed(out), -1024);
    chk("ovr_neg_sat", int'(sat), 1);
    sample(-1);
    chk("round_m1_out", $signed(out), 0);
    chk("round_m1_sat", int'(sat), 0);
    sample(3);
    chk("round_3_out", $signed(out), 2);
    epoch();
    chk("track_grow_index", int'(index), 13);

    sample(64'd1 << 19);
    epoch();
    chk("track_grow20_index", int'(index), 20);
    sample(100);
    epoch();
    chk("track_dec1_index", int'(index), 19);
    epoch();
    chk("track_dec2_index", int'(index), 18);
    for (int i = 0; i < 8; i++) epoch();
    chk("track_floor_index", int'(index), 10);
    epoch();
    chk("track_floor_hold", int'(index), 10);

    sample(5);
    chk("noround_5_out", $signed(out), 5);
    sample(1023);
    chk("edge_1023_out", $signed(out), 1023);
    chk("edge_1023_sat", int'(sat), 0);
    sample(1024);
    chk("edge_1024_out", $signed(out), 1023);
    chk("edge_1024_sat", int'(sat), 1);
    sample(-1024);
    chk("edge_m1024_out", $signed(out), -1024);
    chk("edge_m1024_sat", int'(sat), 0);

    manual = 1'b1; manual_index = 6'd40;
    tick();
    chk("manual_hi_clamp", int'(index), 35);
    manual_index = 6'd3;
    tick();
    chk("manual_lo_clamp", int'(index), 10);
    manual_index = 6'd40;
    sample(200);
    epoch();
    chk("manual_ignores_epoch", int'(index), 35);
    manual = 1'b0;
    sample(1500);
    epoch();
    chk("release_acquire_index", int'(index), 11);

    in = 36'(5000); in_valid = 1'b1; epoch_end = 1'b1;
    tick();
    in_valid = 1'b0; epoch_end = 1'b0;
    chk("simul_out_old_index", $signed(out), 1023);
    chk("simul_sat", int'(sat), 1);
    chk("simul_new_index", int'(index), 13);
    epoch();
    chk("simul_next_epoch_fresh", int'(index), 12);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dll_auto_truncate.md
# dll_auto_truncate

Auto-ranging successor to the fixed-index DLL truncator: selects a signed OUT_WIDTH window from a signed IN_WIDTH accumulator, rounds and saturates it, and derives the window index itself from the peak magnitude seen over each integration epoch. Sits between the early/late/prompt correlator accumulators and the DLL discriminator. A manual override keeps the legacy externally-indexed behaviour available.

## Interface
- IN_WIDTH, 36, accumulator width (signed two's complement)
- OUT_WIDTH, 11, truncated output width (signed)
- INDEX_WIDTH, 6, index width; 2^INDEX_WIDTH ≥ IN_WIDTH
- MIN_INDEX, OUT_WIDTH-1, lowest legal window MSB index
---
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  sample strobe
- in  in  IN_WIDTH  accumulator sample
- epoch_end  in  1  single-cycle pulse closing an integration epoch
- manual  in  1  1 = use manual_index, ignore auto-ranging
- manual_index  in  INDEX_WIDTH  externally chosen window MSB index
- out_valid  out  1  registered copy of in_valid
- out  out  OUT_WIDTH  truncated, rounded, saturated sample
- sat  out  1  out was clipped (high with out_valid only)
- index  out  INDEX_WIDTH  window MSB index currently in use

## Operation
- Window: out = in[index : index-OUT_WIDTH+1] plus round bit in[index-OUT_WIDTH] (none when index = MIN_INDEX); round-half-up.
- Saturation: if bits in[IN_WIDTH-1 : index] are not all equal, or rounding overflows positive, out = +max (sign 0) or −max−1 (sign 1) per in's sign; sat = 1.
- Magnitude: mag = in[IN_WIDTH-1] ? ~in : in (no overflow at most-negative value). peak = running max of mag over valid samples in epoch.
- Required index req = (position of highest set bit of peak) + 1, or MIN_INDEX if peak = 0; clamped to [MIN_INDEX, IN_WIDTH-1].
- FSM, two states:
  - ACQUIRE (after reset, after manual released): at epoch_end index ← req; go TRACK.
  - TRACK: at epoch_end, if req > index then index ← req; if req < index then index ← index-1; equal: hold.
- Manual: while manual = 1, index ← clamp(manual_index) every cycle, epoch updates ignored, FSM forced to ACQUIRE; peak still tracked and cleared at epoch_end.
- peak clears at every epoch_end.

## Timing
- Reset values: out = 0, out_valid = 0, sat = 0, index = IN_WIDTH-1, peak = 0, state = ACQUIRE.
- Latency 1: out/out_valid/sat register the sample presented with in_valid one cycle earlier, using index value in that cycle.
- in_valid and epoch_end together: the sample is included in the closing epoch's peak and truncated with the old index; new index visible the following cycle; next epoch's peak starts at 0.
- epoch_end with no valid samples: peak = 0, req = MIN_INDEX.
- out/sat hold last value when out_valid = 0.
- Reset mid-epoch discards peak; reset wins over all other inputs.

## Structure
- Shared package: index clamp function, highest-set-bit (priority encoder) function, FSM state enum.
- One sub-module natural: dll_window_round (combinational window select, round, saturate), reusable by the carrier loop.

## Test plan
(IN_WIDTH 36, OUT_WIDTH 11)
- After reset, in = 1000·2^25, in_valid -> next cycle out = 1000, sat = 0, index = 35.
- ACQUIRE: epoch of samples peaking at +1500, epoch_end -> index = 11; then in = 1500 -> out = 750, sat = 0.
- TRACK decrease: index = 20, epoch peak 100 -> index 19 after epoch_end, 18 after next; never below 10.
- Overrange: index = 11, in = +5000 -> out = 1023, sat = 1; in = −5000 -> out = −1024, sat = 1; epoch_end -> index = 13 in one step.
- Rounding: index = 11, in = −1 -> out = 0; in = 3 -> out = 2; index = 10, in = 5 -> out = 5 (no round bit).
- Manual/simultaneous: manual = 1, manual_index = 40 -> index = 35; release, epoch peak 1500 -> index = 11 (ACQUIRE jump); in_valid with epoch_end uses old index for that sample.
